// File: rtl/sram_controller.sv
// Splits 32-bit MEM-stage loads/stores into two 16-bit SRAM accesses (low half first),
// holding ready low until the whole word has been transferred.
module sram_controller #(
   parameter int unsigned SRAM_WAIT = 1,
   parameter int unsigned ADDR_BASE = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wr_en,
   input  logic        rd_en,
   input  logic [31:0] address,
   input  logic [31:0] write_data,
   output logic [31:0] read_data,
   output logic        ready,
   output logic [17:0] sram_addr,
   output logic [15:0] sram_dq_out,
   input  logic [15:0] sram_dq_in,
   output logic        sram_dq_oe,
   output logic        sram_we_n
);

   localparam int unsigned CntW = (SRAM_WAIT > 0) ? $clog2(SRAM_WAIT + 1) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'(SRAM_WAIT);

   typedef enum logic [1:0] {StIdle, StLo, StHi, StDone} state_e;

   state_e          state_q, state_d;
   logic [CntW-1:0] wait_q, wait_d;
   logic            op_wr_q, op_wr_d;
   logic [16:0]     word_q, word_d;
   logic [31:0]     wdata_q, wdata_d;
   logic [15:0]     lo_buf_q, lo_buf_d;
   logic [31:0]     read_data_q, read_data_d;
   logic [17:0]     addr_q, addr_d;
   logic [15:0]     dq_out_q, dq_out_d;
   logic            oe_q, oe_d;
   logic            we_n_q, we_n_d;

   logic        req;
   logic        last;
   logic [16:0] word_in;

   assign req     = rd_en | wr_en;
   assign last    = (wait_q == CntLast);
   assign word_in = 17'((address - ADDR_BASE) >> 2);

   // SRAM pins are registered from next-state so they are valid for the whole phase.
   always_comb begin
      state_d     = state_q;
      wait_d      = wait_q;
      op_wr_d     = op_wr_q;
      word_d      = word_q;
      wdata_d     = wdata_q;
      lo_buf_d    = lo_buf_q;
      read_data_d = read_data_q;
      addr_d      = addr_q;
      dq_out_d    = dq_out_q;
      oe_d        = 1'b0;
      we_n_d      = 1'b1;
      ready       = 1'b0;

      unique case (state_q)
         StIdle: begin
            ready = ~req;
            if (req) begin
               state_d = StLo;
               wait_d  = '0;
               op_wr_d = wr_en;
               word_d  = word_in;
               wdata_d = write_data;
               addr_d  = {word_in, 1'b0};
               if (wr_en) begin
                  dq_out_d = write_data[15:0];
                  oe_d     = 1'b1;
                  we_n_d   = 1'b0;
               end
            end
         end
         StLo: begin
            oe_d   = op_wr_q;
            we_n_d = ~op_wr_q;
            if (last) begin
               state_d = StHi;
               wait_d  = '0;
               addr_d  = {word_q, 1'b1};
               if (op_wr_q) dq_out_d = wdata_q[31:16];
               else         lo_buf_d = sram_dq_in;
            end else begin
               wait_d = wait_q + CntW'(1);
            end
         end
         StHi: begin
            if (last) begin
               state_d = StDone;
               if (!op_wr_q) read_data_d = {sram_dq_in, lo_buf_q};
            end else begin
               wait_d = wait_q + CntW'(1);
               oe_d   = op_wr_q;
               we_n_d = ~op_wr_q;
            end
         end
         StDone: begin
            ready   = 1'b1;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         wait_q      <= '0;
         op_wr_q     <= 1'b0;
         word_q      <= '0;
         wdata_q     <= '0;
         lo_buf_q    <= '0;
         read_data_q <= '0;
         addr_q      <= '0;
         dq_out_q    <= '0;
         oe_q        <= 1'b0;
         we_n_q      <= 1'b1;
      end else begin
         state_q     <= state_d;
         wait_q      <= wait_d;
         op_wr_q     <= op_wr_d;
         word_q      <= word_d;
         wdata_q     <= wdata_d;
         lo_buf_q    <= lo_buf_d;
         read_data_q <= read_data_d;
         addr_q      <= addr_d;
         dq_out_q    <= dq_out_d;
         oe_q        <= oe_d;
         we_n_q      <= we_n_d;
      end
   end

   assign read_data   = read_data_q;
   assign sram_addr   = addr_q;
   assign sram_dq_out = dq_out_q;
   assign sram_dq_oe  = oe_q;
   assign sram_we_n   = we_n_q;

endmodule

// File: tb/tb_sram_controller.sv
// Directed bench for sram_controller: one instance at SRAM_WAIT=1 backed by a small SRAM
// model, one at SRAM_WAIT=3 whose SRAM returns 16'h1000 + half-word address.
module tb_sram_controller;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic        wr1 = 0, rd1 = 0, wr2 = 0, rd2 = 0;
   logic [31:0] addr1 = 0, wd1 = 0, addr2 = 0, wd2 = 0;
   logic [31:0] rdata1, rdata2;
   logic        ready1, ready2, oe1, oe2, we_n1, we_n2;
   logic [17:0] sram_addr1, sram_addr2;
   logic [15:0] dq_out1, dq_out2, dq_in1, dq_in2;

   logic [15:0] mem [0:63];

   sram_controller #(.SRAM_WAIT(1), .ADDR_BASE(1024)) dut1 (
      .clk(clk), .rst(rst), .wr_en(wr1), .rd_en(rd1), .address(addr1), .write_data(wd1),
      .read_data(rdata1), .ready(ready1), .sram_addr(sram_addr1), .sram_dq_out(dq_out1),
      .sram_dq_in(dq_in1), .sram_dq_oe(oe1), .sram_we_n(we_n1)
   );

   sram_controller #(.SRAM_WAIT(3), .ADDR_BASE(1024)) dut2 (
      .clk(clk), .rst(rst), .wr_en(wr2), .rd_en(rd2), .address(addr2), .write_data(wd2),
      .read_data(rdata2), .ready(ready2), .sram_addr(sram_addr2), .sram_dq_out(dq_out2),
      .sram_dq_in(dq_in2), .sram_dq_oe(oe2), .sram_we_n(we_n2)
   );

   always @(posedge clk) if (!we_n1 && oe1) mem[sram_addr1[5:0]] <= dq_out1;
   assign dq_in1 = mem[sram_addr1[5:0]];
   assign dq_in2 = 16'h1000 + sram_addr2[15:0];

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", tag, got, exp);
   endtask

   // Per-cycle observations of the last access, index k = cycles after the request appeared.
   logic [17:0] obs_addr [0:39];
   logic [15:0] obs_dq   [0:39];
   logic        obs_wen  [0:39];
   logic        obs_oe   [0:39];

   task automatic run_access(input bit sel, input bit w, input bit r, input logic [31:0] a,
                             input logic [31:0] d, input int chg, output int lat);
      @(posedge clk); #1;
      if (sel) begin wr2 = w; rd2 = r; addr2 = a; wd2 = d; end
      else     begin wr1 = w; rd1 = r; addr1 = a; wd1 = d; end
      lat = -1;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         obs_addr[k] = sel ? sram_addr2 : sram_addr1;
         obs_dq[k]   = sel ? dq_out2 : dq_out1;
         obs_wen[k]  = sel ? we_n2 : we_n1;
         obs_oe[k]   = sel ? oe2 : oe1;
         if (chg != 0 && k == chg) begin
            if (sel) addr2 = 32'd2000; else addr1 = 32'd2000;
         end
         if (sel ? ready2 : ready1) begin lat = k; break; end
      end
      wr1 = 0; rd1 = 0; wr2 = 0; rd2 = 0;
   endtask

   int lat;

   initial begin
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("reset ready", 32'(ready1), 32'd1);
      check("reset we_n", 32'(we_n1), 32'd1);
      check("reset oe", 32'(oe1), 32'd0);
      check("reset read_data", rdata1, 32'd0);
      check("reset sram_addr", 32'(sram_addr1), 32'd0);

      // 1: write then read back
      run_access(0, 1, 0, 32'd1024, 32'hDEADBEEF, 0, lat);
      check("wr latency", 32'(lat), 32'd5);
      check("wr accept ready", 32'(ready1 && obs_wen[0]), 32'd1);
      check("wr lo addr c1", 32'(obs_addr[1]), 32'd0);
      check("wr lo addr c2", 32'(obs_addr[2]), 32'd0);
      check("wr lo dq", 32'(obs_dq[2]), 32'h0000BEEF);
      check("wr lo we_n", 32'(obs_wen[1]), 32'd0);
      check("wr lo oe", 32'(obs_oe[2]), 32'd1);
      check("wr hi addr c3", 32'(obs_addr[3]), 32'd1);
      check("wr hi addr c4", 32'(obs_addr[4]), 32'd1);
      check("wr hi dq", 32'(obs_dq[4]), 32'h0000DEAD);
      check("wr hi we_n", 32'(obs_wen[4]), 32'd0);
      check("wr done we_n", 32'(obs_wen[5]), 32'd1);
      check("wr done oe", 32'(obs_oe[5]), 32'd0);
      check("wr read_data untouched", rdata1, 32'd0);
      run_access(0, 0, 1, 32'd1024, 32'd0, 0, lat);
      check("rd latency", 32'(lat), 32'd5);
      check("rd data", rdata1, 32'hDEADBEEF);
      check("rd we_n", 32'(obs_wen[2]), 32'd1);
      check("rd oe", 32'(obs_oe[3]), 32'd0);

      // 2: address mapping, low address bits ignored
      run_access(0, 1, 0, 32'd1036, 32'h11112222, 0, lat);
      check("map 1036 lo", 32'(obs_addr[1]), 32'd6);
      check("map 1036 hi", 32'(obs_addr[3]), 32'd7);
      run_access(0, 1, 0, 32'd1039, 32'h33334444, 0, lat);
      check("map 1039 lo", 32'(obs_addr[2]), 32'd6);
      check("map 1039 hi", 32'(obs_addr[4]), 32'd7);
      check("mem[6]", 32'(mem[6]), 32'h00004444);
      check("mem[7]", 32'(mem[7]), 32'h00003333);

      // 3: simultaneous rd/wr performs the write
      run_access(0, 1, 1, 32'd1028, 32'h55556666, 0, lat);
      check("both we_n", 32'(obs_wen[1]), 32'd0);
      check("both read_data kept", rdata1, 32'hDEADBEEF);
      check("both mem[2]", 32'(mem[2]), 32'h00006666);
      check("both mem[3]", 32'(mem[3]), 32'h00005555);

      // 4: idle for 10 cycles
      @(posedge clk);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("idle ready", 32'(ready1), 32'd1);
         check("idle we_n", 32'(we_n1), 32'd1);
         check("idle oe", 32'(oe1), 32'd0);
      end

      // 5: reset during 2nd HI cycle of a write
      @(posedge clk); #1;
      wr1 = 1; addr1 = 32'd1040; wd1 = 32'hAAAABBBB;
      repeat (5) @(negedge clk);
      check("pre-rst hi we_n", 32'(we_n1), 32'd0);
      rst = 1'b1; wr1 = 0;
      @(negedge clk);
      check("rst we_n", 32'(we_n1), 32'd1);
      check("rst oe", 32'(oe1), 32'd0);
      check("rst read_data", rdata1, 32'd0);
      check("rst ready", 32'(ready1), 32'd1);
      rst = 1'b0;

      // 6: SRAM_WAIT=3 write then read with the address changed mid-access
      run_access(1, 1, 0, 32'd1044, 32'hCAFEF00D, 0, lat);
      check("w3 wr latency", 32'(lat), 32'd9);
      check("w3 wr lo dq", 32'(obs_dq[4]), 32'h0000F00D);
      check("w3 wr hi dq", 32'(obs_dq[5]), 32'h0000CAFE);
      check("w3 wr hi we_n", 32'(obs_wen[8]), 32'd0);
      run_access(1, 0, 1, 32'd1044, 32'd0, 2, lat);
      check("w3 rd latency", 32'(lat), 32'd9);
      check("w3 lo addr c1", 32'(obs_addr[1]), 32'd10);
      check("w3 lo addr c4", 32'(obs_addr[4]), 32'd10);
      check("w3 hi addr c5", 32'(obs_addr[5]), 32'd11);
      check("w3 hi addr c8", 32'(obs_addr[8]), 32'd11);
      check("w3 rd we_n", 32'(obs_wen[3]), 32'd1);
      check("w3 rd data", rdata2, 32'h100B100A);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
